key_store: RTL and testbench

KEY_STORE -- requirements
Module: key_store

---
 rtl/crypto_pkg.sv | 11 +
 rtl/key_slot.sv | 40 ++++
 rtl/key_store.sv | 153 +++++++++++++++
 tb/tb_key_store.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// Shared definitions for the key store: widths and the read/zeroize FSM encoding.
package crypto_pkg;
   localparam int KEY_W  = 256;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_ZERO = 2'd2
   } state_e;
endpackage

// File: rtl/key_slot.sv
// One key slot: SLOT_WORDS x 32-bit data words plus a per-word written mask.
module key_slot
   import crypto_pkg::*;
#(
   parameter int SLOT_WORDS = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         clr_i,
   input  logic                         wr_en_i,
   input  logic [2:0]                   wr_idx_i,
   input  logic [WORD_W-1:0]            wr_data_i,
   output logic [SLOT_WORDS*WORD_W-1:0] data_o,
   output logic [SLOT_WORDS-1:0]        mask_o
);

   logic [WORD_W-1:0]     data_q [SLOT_WORDS];
   logic [SLOT_WORDS-1:0] mask_q;

   // Clear takes priority so a zeroize sweep always leaves the slot empty.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < SLOT_WORDS; w++) data_q[w] <= '0;
         mask_q <= '0;
      end else if (clr_i) begin
         for (int w = 0; w < SLOT_WORDS; w++) data_q[w] <= '0;
         mask_q <= '0;
      end else if (wr_en_i) begin
         data_q[wr_idx_i] <= wr_data_i;
         mask_q[wr_idx_i] <= 1'b1;
      end
   end

   for (genvar gi = 0; gi < SLOT_WORDS; gi++) begin : g_pack
      assign data_o[gi*WORD_W +: WORD_W] = data_q[gi];
   end

   assign mask_o = mask_q;

endmodule

// File: rtl/key_store.sv
// Multi-slot key store: word-wise key loading, one-shot whole-key reads for
// the cipher core, and a slot-by-slot zeroize sweep.
module key_store
   import crypto_pkg::*;
#(
   parameter int NUM_SLOTS  = 6,
   parameter int SLOT_WORDS = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WORD_W-1:0]    wordIn,
   input  logic [4:0]           sliceSelector,
   input  logic [NUM_SLOTS-1:0] writeEnableKey,
   input  logic                 zeroize,
   input  logic                 keyReq,
   input  logic [2:0]           keyIdx,
   output logic [KEY_W-1:0]     keyOut,
   output logic                 keyAck,
   output logic                 keyErr,
   output logic [NUM_SLOTS-1:0] keyValid,
   output logic [NUM_SLOTS-1:0] keyFull,
   output logic                 busy,
   output logic                 wrErr
);

   localparam int CNT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [KEY_W-1:0]     key_out_q, key_out_d;
   logic                 ack_q, ack_d;
   logic                 err_q, err_d;
   logic                 wr_err_q, wr_err_d;

   logic                 busy_w;
   logic                 wr_onehot;
   logic                 wr_ok;
   logic                 wr_bad;
   logic                 rd_hit;
   logic [KEY_W-1:0]     rd_merged;
   logic [KEY_W-1:0]     slot_data [NUM_SLOTS];
   logic [SLOT_WORDS-1:0] slot_mask [NUM_SLOTS];

   assign busy_w    = (state_q == ST_ZERO);
   assign wr_onehot = (writeEnableKey != '0) &&
                      ((writeEnableKey & (writeEnableKey - NUM_SLOTS'(1))) == '0);
   assign wr_ok     = wr_onehot && (sliceSelector[4:3] == 2'b00) && !busy_w;
   assign wr_bad    = (writeEnableKey != '0) && !wr_ok;

   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      key_slot #(
         .SLOT_WORDS(SLOT_WORDS)
      ) u_slot (
         .clock    (clock),
         .reset    (reset),
         .clr_i    (busy_w && (cnt_q == CNT_W'(gi))),
         .wr_en_i  (wr_ok && writeEnableKey[gi]),
         .wr_idx_i (sliceSelector[2:0]),
         .wr_data_i(wordIn),
         .data_o   (slot_data[gi]),
         .mask_o   (slot_mask[gi])
      );
      assign keyValid[gi] = &slot_mask[gi][3:0];
      assign keyFull[gi]  = &slot_mask[gi];
   end

   assign rd_hit = ({29'd0, idx_q} < NUM_SLOTS) && keyValid[idx_q];

   // A write landing on the same edge as the read is forwarded into keyOut.
   always_comb begin
      rd_merged = slot_data[idx_q];
      for (int w = 0; w < SLOT_WORDS; w++) begin
         if (wr_ok && writeEnableKey[idx_q] && (sliceSelector[2:0] == 3'(w)))
            rd_merged[w*WORD_W +: WORD_W] = wordIn;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      key_out_d = key_out_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      wr_err_d  = wr_err_q | wr_bad;
      case (state_q)
         ST_IDLE: begin
            if (zeroize) begin
               state_d   = ST_ZERO;
               cnt_d     = '0;
               key_out_d = '0;
            end else if (keyReq) begin
               idx_d   = keyIdx;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (zeroize) begin
               state_d   = ST_ZERO;
               cnt_d     = '0;
               key_out_d = '0;
            end else begin
               state_d = ST_IDLE;
               if (rd_hit) begin
                  key_out_d = rd_merged;
                  ack_d     = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_ZERO: begin
            if (cnt_q == CNT_W'(NUM_SLOTS - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         key_out_q <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         wr_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         key_out_q <= key_out_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         wr_err_q  <= wr_err_d;
      end
   end

   assign keyOut = key_out_q;
   assign keyAck = ack_q;
   assign keyErr = err_q;
   assign busy   = busy_w;
   assign wrErr  = wr_err_q;

endmodule

// File: tb/tb_key_store.sv
// Directed self-checking bench for key_store: load, read, errors, zeroize, reset.
module tb_key_store;

   logic         clock;
   logic         reset;
   logic [31:0]  wordIn;
   logic [4:0]   sliceSelector;
   logic [5:0]   writeEnableKey;
   logic         zeroize;
   logic         keyReq;
   logic [2:0]   keyIdx;
   logic [255:0] keyOut;
   logic         keyAck;
   logic         keyErr;
   logic [5:0]   keyValid;
   logic [5:0]   keyFull;
   logic         busy;
   logic         wrErr;

   int total = 0;
   int bad   = 0;
   int busy_cnt;
   logic [255:0] exp_key;

   key_store dut (
      .clock         (clock),
      .reset         (reset),
      .wordIn        (wordIn),
      .sliceSelector (sliceSelector),
      .writeEnableKey(writeEnableKey),
      .zeroize       (zeroize),
      .keyReq        (keyReq),
      .keyIdx        (keyIdx),
      .keyOut        (keyOut),
      .keyAck        (keyAck),
      .keyErr        (keyErr),
      .keyValid      (keyValid),
      .keyFull       (keyFull),
      .busy          (busy),
      .wrErr         (wrErr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [5:0] we, input logic [4:0] sl, input logic [31:0] d);
      writeEnableKey = we;
      sliceSelector  = sl;
      wordIn         = d;
      tick();
      writeEnableKey = '0;
      sliceSelector  = '0;
      $display("write we=%b slice=%b data=%h wrErr=%b", we, sl, d, wrErr);
   endtask

   // Issues a one-cycle request and returns just after the response edge.
   task automatic req(input logic [2:0] idx);
      keyReq = 1'b1;
      keyIdx = idx;
      tick();
      keyReq = 1'b0;
      chk1("ack_not_early", keyAck, 1'b0);
      tick();
      $display("read idx=%0d ack=%b err=%b keyOut=%h", idx, keyAck, keyErr, keyOut);
   endtask

   initial begin
      reset          = 1'b1;
      wordIn         = '0;
      sliceSelector  = '0;
      writeEnableKey = '0;
      zeroize        = 1'b0;
      keyReq         = 1'b0;
      keyIdx         = '0;
      tick();
      tick();
      chk256("rst_keyOut", keyOut, '0);
      chk1("rst_ack", keyAck, 1'b0);
      chk1("rst_err", keyErr, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_wrErr", wrErr, 1'b0);
      reset = 1'b0;
      chk6("rst_valid", keyValid, 6'b0);
      chk6("rst_full", keyFull, 6'b0);

      // Basic load of the lower 128 bits of slot 0 and read-back.
      wr(6'b000001, 5'd0, 32'he0318a99);
      wr(6'b000001, 5'd1, 32'h23f247b3);
      wr(6'b000001, 5'd2, 32'hed8ff212);
      chk1("valid_partial", keyValid[0], 1'b0);
      wr(6'b000001, 5'd3, 32'hef0bc156);
      chk1("valid_after_4", keyValid[0], 1'b1);
      chk1("full_after_4", keyFull[0], 1'b0);
      req(3'd0);
      exp_key = {128'd0, 128'hef0bc156_ed8ff212_23f247b3_e0318a99};
      chk1("load_ack", keyAck, 1'b1);
      chk1("load_err", keyErr, 1'b0);
      chk256("load_keyOut", keyOut, exp_key);
      tick();
      chk1("ack_one_cycle", keyAck, 1'b0);

      // Rejected reads: empty slot and out-of-range index.
      req(3'd3);
      chk1("err3_err", keyErr, 1'b1);
      chk1("err3_ack", keyAck, 1'b0);
      chk256("err3_keyOut", keyOut, exp_key);
      tick();
      chk1("err_one_cycle", keyErr, 1'b0);
      req(3'd7);
      chk1("err7_err", keyErr, 1'b1);
      chk1("err7_ack", keyAck, 1'b0);
      chk256("err7_keyOut", keyOut, exp_key);

      // Illegal writes leave the slot untouched and latch wrErr.
      chk1("wrErr_clean", wrErr, 1'b0);
      wr(6'b000011, 5'd4, 32'hdeadbeef);
      chk1("wrErr_multi", wrErr, 1'b1);
      wr(6'b000001, 5'b01000, 32'hcafef00d);
      chk1("wrErr_sticky", wrErr, 1'b1);
      chk6("full_after_bad", keyFull, 6'b0);
      chk6("valid_after_bad", keyValid, 6'b000001);
      req(3'd0);
      chk1("bad_read_ack", keyAck, 1'b1);
      chk256("bad_keyOut", keyOut, exp_key);

      // Write landing on the READ edge is visible in keyOut.
      keyReq = 1'b1;
      keyIdx = 3'd0;
      tick();
      keyReq = 1'b0;
      wr(6'b000001, 5'd0, 32'h12345678);
      exp_key = {128'd0, 128'hef0bc156_ed8ff212_23f247b3_12345678};
      chk1("byp_ack", keyAck, 1'b1);
      chk256("byp_keyOut", keyOut, exp_key);

      // Reset arriving in the READ cycle.
      keyReq = 1'b1;
      keyIdx = 3'd0;
      tick();
      keyReq = 1'b0;
      reset  = 1'b1;
      #1;
      chk1("midrd_ack", keyAck, 1'b0);
      chk256("midrd_keyOut", keyOut, '0);
      chk6("midrd_valid", keyValid, 6'b0);
      chk6("midrd_full", keyFull, 6'b0);
      chk1("midrd_wrErr", wrErr, 1'b0);
      chk1("midrd_busy", busy, 1'b0);
      tick();
      chk1("midrd_ack_late", keyAck, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) wr(6'b000001, 5'(i), 32'h11110000 + 32'(i));
      chk1("reload_full", keyFull[0], 1'b1);
      req(3'd0);
      chk1("reload_ack", keyAck, 1'b1);
      chk256("reload_keyOut", keyOut,
             256'h11110007_11110006_11110005_11110004_11110003_11110002_11110001_11110000);

      // Zeroize sweep.
      for (int i = 0; i < 8; i++) wr(6'b100000, 5'(i), 32'h55550000 + 32'(i));
      chk6("pre_zero_full", keyFull, 6'b100001);
      chk6("pre_zero_valid", keyValid, 6'b100001);
      req(3'd5);
      chk1("slot5_ack", keyAck, 1'b1);
      chk256("slot5_keyOut", keyOut,
             256'h55550007_55550006_55550005_55550004_55550003_55550002_55550001_55550000);
      zeroize = 1'b1;
      tick();
      zeroize = 1'b0;
      chk1("zero_busy", busy, 1'b1);
      chk256("zero_keyOut", keyOut, '0);
      busy_cnt = 1;
      wr(6'b000010, 5'd0, 32'haaaaaaaa);
      chk1("zero_wrErr", wrErr, 1'b1);
      if (busy) busy_cnt++;
      zeroize = 1'b1;
      wr(6'b000001, 5'd0, 32'h99999999);
      zeroize = 1'b0;
      if (busy) busy_cnt++;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (busy) busy_cnt++;
      end
      $display("zeroize busy cycles=%0d", busy_cnt);
      total++;
      assert (busy_cnt == 6) else begin
         bad++;
         $error("FAIL zero_busy_len observed=%0d expected=%0d", busy_cnt, 6);
      end
      chk1("post_zero_busy", busy, 1'b0);
      chk6("post_zero_valid", keyValid, 6'b0);
      chk6("post_zero_full", keyFull, 6'b0);
      chk256("post_zero_keyOut", keyOut, '0);

      // The write attempted during the sweep must not have reached slot 0.
      wr(6'b000001, 5'd1, 32'hb0b00001);
      wr(6'b000001, 5'd2, 32'hb0b00002);
      wr(6'b000001, 5'd3, 32'hb0b00003);
      chk1("blocked_word0", keyValid[0], 1'b0);
      wr(6'b000001, 5'd0, 32'ha0a0a0a0);
      chk6("post_zero_reload", keyValid, 6'b000001);
      req(3'd0);
      chk1("post_zero_ack", keyAck, 1'b1);
      chk256("post_zero_read", keyOut, {128'd0, 128'hb0b00003_b0b00002_b0b00001_a0a0a0a0});
      chk1("wrErr_still", wrErr, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
